lcd_driver: RTL and testbench
=============================

# lcd_driver

HD44780-compatible character LCD controller in 8-bit, write-only mode, placed downstream of the CPU core to drive the `lcd_ctrl`/`lcd_en`/`lcd_rw`/`lcd_rs` pins. After reset it runs the power-on init sequence on its own. It then accepts characters and commands from the core over a valid/ready handshake. It generates the enable-pulse timing and command-execution delays, and optionally tracks the cursor position to wrap between the two display lines.

## Interface
Parameters:
- `POR_CYCLES`, 540000: power-on wait before the first init command (20 ms at 27 MHz).
- `EN_CYCLES`, 12: width of the `lcd_en` high pulse.
- `EXEC_CYCLES`, 1200: post-pulse wait for normal commands and data.
- `CLEAR_CYCLES`, 50000: post-pulse wait for clear (0x01) and home (0x02/0x03) commands.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset. One clock; all state is in the `clk` domain.
- `char_valid` input 1: a request is presented.
- `char_data` input 8: character code or command byte.
- `char_is_cmd` input 1: 1 = command (RS=0), 0 = data (RS=1).
- `char_ready` output 1: driver can accept a request.
- `init_done` output 1: init sequence complete; stays high until the next reset.
- `lcd_data` output 8: LCD D7..D0.
- `lcd_en` output 1: LCD enable strobe.
- `lcd_rw` output 1: tied 0.
- `lcd_rs` output 1: register select.

## Operation
- Reset values: all outputs 0; the FSM is in `POR_WAIT`; cursor is col=0, line=0.
- FSM states: `POR_WAIT` → `INIT` → `IDLE` → `SETUP` → `EN_HI` → `EXEC_WAIT` → (`WRAP_SETUP` → `EN_HI` → `EXEC_WAIT`) → `IDLE`.
- **POR_WAIT**: counts `POR_CYCLES`, then enters `INIT`.
- **INIT**: sends the ROM bytes 0x38, 0x0C, 0x01, 0x06 with RS=0, each through `SETUP`/`EN_HI`/`EXEC_WAIT`. After the last one, `init_done`=1 and the FSM enters `IDLE`.
- **Handshake**:
  - `char_ready`=1 only in `IDLE` with `init_done`=1.
  - A transfer occurs on a rising edge with `char_valid`&&`char_ready`; `char_data`/`char_is_cmd` are captured on that edge.
  - Requests presented while not ready are ignored until ready. No buffering.
- **Write cycle**:
  - `SETUP` (1 cycle) drives `lcd_rs`/`lcd_data`; `lcd_en`=0.
  - `EN_HI` holds `lcd_en`=1 for `EN_CYCLES`.
  - `EXEC_WAIT` drives `lcd_en`=0 with data and RS held for its full duration.
  - Its length is `CLEAR_CYCLES` when the byte is a command of 0x01, 0x02 or 0x03, otherwise `EXEC_CYCLES`.
- After `EXEC_WAIT`, the FSM returns to `IDLE`, or to `WRAP_SETUP` if a wrap is pending (see Configuration).
- `lcd_rw` is constant 0. There is no busy-flag polling; delays are purely counted.
- Counters are sized to `$clog2` of the largest parameter + 1. Counts load at state entry and terminate at the value 1, so each state lasts exactly its parameter value.
- **Reset mid-operation**: `lcd_en` drops to 0 asynchronously and all state returns to reset values. The full init sequence reruns.

## Timing
- Acceptance edge at T: `SETUP` at T+1, `lcd_en` high on cycles T+2 .. T+1+`EN_CYCLES`.
- `char_ready` goes high again at T+1+`EN_CYCLES`+`EXEC` (no wrap). Each write therefore costs 1+`EN_CYCLES`+`EXEC` cycles.
- `lcd_rs`/`lcd_data` are stable 1 cycle before the rising edge of `lcd_en` and for at least `EXEC` cycles after its falling edge.
- An auto-wrap adds 1+`EN_CYCLES`+`EXEC_CYCLES` cycles before `char_ready` returns.
- `init_done` rises on the same edge the FSM enters `IDLE` after the 0x06 wait.

## Configuration
- Macro `LCD_AUTOWRAP_EN`.
- **Defined**: the block tracks cursor position (4-bit col, 1-bit line).
  - Each data write increments col. When col wraps from 15 to 0, the driver inserts command 0xC0 (line 0→1) or 0x80 (line 1→0) and toggles line.
  - Command 0x01/0x02/0x03 sets col=0, line=0.
  - A command with bit7=1 sets line=bit6, col=bits[3:0].
  - Other commands leave the cursor unchanged.
- **Undefined**: no tracking and no inserted commands. `WRAP_SETUP` is unreachable.

## Test plan
Parameters for all tests: POR_CYCLES=20, EN_CYCLES=2, EXEC_CYCLES=4, CLEAR_CYCLES=10.

- **Release reset** → no `lcd_en` activity for 20 cycles. Then four 2-cycle `lcd_en` pulses with RS=0 and data 0x38, 0x0C, 0x01, 0x06. The gap after 0x01 is 10 cycles, the others 4. `init_done` rises after 0x06; `lcd_rw`=0 throughout.
- **Send data 0x41 accepted at T** → `lcd_rs`=1, `lcd_data`=0x41 from T+1; `lcd_en` high exactly at T+2..T+3; `char_ready` returns at T+7.
- **Command 0x01** → 10-cycle exec wait; `char_ready` returns 13 cycles after acceptance. With AUTOWRAP, the next 16 data writes are followed by an inserted 0xC0.
- **`LCD_AUTOWRAP_EN`, 32 data bytes after init** → 0xC0 (RS=0) inserted after the 16th byte and 0x80 after the 32nd. Without the macro, no inserted commands.
- **`char_valid` held high with two different bytes across a busy period** → only one `lcd_en` pulse per `char_ready` assertion; bytes presented while `char_ready`=0 are not written.
- **Assert `rst` while `lcd_en`=1** → `lcd_en`, `lcd_rs`, `lcd_data`, `init_done` and `char_ready` are 0 immediately (same cycle). After release, the 20-cycle wait and the full init sequence repeat.

Source files
------------

// File: rtl/lcd_driver.sv
// lcd_driver: HD44780-compatible 8-bit write-only LCD controller with power-on init and counted timing.
// Define LCD_AUTOWRAP_EN to track the cursor and insert line-change commands when a line fills.
module lcd_driver #(
  parameter int POR_CYCLES   = 540000,
  parameter int EN_CYCLES    = 12,
  parameter int EXEC_CYCLES  = 1200,
  parameter int CLEAR_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  input  logic       char_is_cmd,
  output logic       char_ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs
);

  localparam int MAX_A      = (POR_CYCLES > EN_CYCLES) ? POR_CYCLES : EN_CYCLES;
  localparam int MAX_B      = (EXEC_CYCLES > CLEAR_CYCLES) ? EXEC_CYCLES : CLEAR_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] POR_LOAD   = CW'(POR_CYCLES);
  localparam logic [CW-1:0] EN_LOAD    = CW'(EN_CYCLES);
  localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES);

  typedef enum logic [2:0] {
    POR_WAIT,
    INIT,
    IDLE,
    SETUP,
    EN_HI,
    EXEC_WAIT,
    WRAP_SETUP
  } state_t;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic [1:0]    init_idx_q, init_idx_d;
  logic          init_done_q, init_done_d;
  logic          ready_int;

`ifdef LCD_AUTOWRAP_EN
  logic [3:0]    col_q, col_d;
  logic          line_q, line_d;
  logic          wrap_pend_q, wrap_pend_d;
`endif

  assign ready_int = (state_q == IDLE) && init_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
`ifdef LCD_AUTOWRAP_EN
    col_d       = col_q;
    line_d      = line_q;
    wrap_pend_d = wrap_pend_q;
`endif
    case (state_q)
      POR_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = INIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      INIT: begin
        data_d  = init_rom(init_idx_q);
        rs_d    = 1'b0;
        state_d = SETUP;
      end
      IDLE: begin
        if (char_valid && ready_int) begin
          data_d  = char_data;
          rs_d    = !char_is_cmd;
          state_d = SETUP;
`ifdef LCD_AUTOWRAP_EN
          if (!char_is_cmd) begin
            col_d = col_q + 4'd1;
            if (col_q == 4'hF) begin
              wrap_pend_d = 1'b1;
            end
          end else if (is_slow_cmd(1'b0, char_data)) begin
            col_d  = 4'd0;
            line_d = 1'b0;
          end else if (char_data[7]) begin
            line_d = char_data[6];
            col_d  = char_data[3:0];
          end
`endif
        end
      end
      SETUP, WRAP_SETUP: begin
        cnt_d   = EN_LOAD;
        state_d = EN_HI;
      end
      EN_HI: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = is_slow_cmd(rs_q, data_q) ? CLEAR_LOAD : EXEC_LOAD;
          state_d = EXEC_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      EXEC_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          if (!init_done_q) begin
            if (init_idx_q == 2'd3) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              init_idx_d = init_idx_q + 2'd1;
              state_d    = INIT;
            end
          end else begin
            state_d = IDLE;
`ifdef LCD_AUTOWRAP_EN
            // Line just filled: move the LCD cursor to the start of the other line.
            if (wrap_pend_q) begin
              wrap_pend_d = 1'b0;
              data_d      = line_q ? 8'h80 : 8'hC0;
              rs_d        = 1'b0;
              line_d      = ~line_q;
              state_d     = WRAP_SETUP;
            end
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = POR_WAIT;
        cnt_d   = POR_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= POR_WAIT;
      cnt_q       <= POR_LOAD;
      data_q      <= 8'd0;
      rs_q        <= 1'b0;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
      col_q       <= 4'd0;
      line_q      <= 1'b0;
      wrap_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
`ifdef LCD_AUTOWRAP_EN
      col_q       <= col_d;
      line_q      <= line_d;
      wrap_pend_q <= wrap_pend_d;
`endif
    end
  end

  // Enable is decoded straight from the state flop so reset drops it without waiting for a clock.
  assign lcd_en     = (state_q == EN_HI);
  assign lcd_rw     = 1'b0;
  assign lcd_rs     = rs_q;
  assign lcd_data   = data_q;
  assign init_done  = init_done_q;
  assign char_ready = ready_int;

endmodule

// File: tb/tb_lcd_driver.sv
// Scoreboard bench for lcd_driver: stimulus pushes expected LCD writes and latencies, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_lcd_driver;
  localparam int POR  = 20;
  localparam int EN   = 2;
  localparam int EXEC = 4;
  localparam int CLR  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'd0;
  logic       char_is_cmd = 1'b0;
  logic       char_ready, init_done, lcd_en, lcd_rw, lcd_rs;
  logic [7:0] lcd_data;

  lcd_driver #(
    .POR_CYCLES(POR), .EN_CYCLES(EN), .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLR)
  ) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_is_cmd(char_is_cmd), .char_ready(char_ready), .init_done(init_done),
    .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exec;
  } wr_t;

  wr_t wq[$];
  int  lat_q[$];
  int  checks = 0;
  int  errors = 0;
  int  m_col  = 0;
  int  m_line = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail(string name, int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=none", name, act);
  endtask

  function automatic int exec_of(bit is_cmd, logic [7:0] d);
    return (is_cmd && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLR : EXEC;
  endfunction

  function automatic void push_wr(bit rs, logic [7:0] d, int ex);
    wr_t w;
    w.rs = rs; w.data = d; w.exec = ex;
    wq.push_back(w);
  endfunction

  // Reference model: what the LCD should see for one accepted request, and when ready returns.
  function automatic void model_issue(logic [7:0] d, bit is_cmd);
    int ex  = exec_of(is_cmd, d);
    int lat = 1 + EN + ex;
    push_wr(!is_cmd, d, ex);
`ifdef LCD_AUTOWRAP_EN
    if (!is_cmd) begin
      m_col = m_col + 1;
      if (m_col == 16) begin
        m_col = 0;
        push_wr(1'b0, (m_line != 0) ? 8'h80 : 8'hC0, EXEC);
        m_line = 1 - m_line;
        lat = lat + 1 + EN + EXEC;
      end
    end else if (d == 8'h01 || d == 8'h02 || d == 8'h03) begin
      m_col = 0; m_line = 0;
    end else if (d[7]) begin
      m_line = int'(d[6]);
      m_col  = int'(d[3:0]);
    end
`endif
    lat_q.push_back(lat);
  endfunction

  function automatic void model_init();
    push_wr(1'b0, 8'h38, exec_of(1'b1, 8'h38));
    push_wr(1'b0, 8'h0C, exec_of(1'b1, 8'h0C));
    push_wr(1'b0, 8'h01, exec_of(1'b1, 8'h01));
    push_wr(1'b0, 8'h06, exec_of(1'b1, 8'h06));
    m_col = 0; m_line = 0;
  endfunction

  // Monitor
  logic       prev_en = 1'b0, prev_rs = 1'b0, prev_idone = 1'b0;
  logic [7:0] prev_data = 8'd0;
  wr_t        cur;
  bit         post = 1'b0, acc_trk = 1'b0, first_en = 1'b0;
  int         hi_cnt = 0, low_cnt = 0, pulses = 0, por_smp = 0, acc_smp = 0;

  always @(negedge clk) begin
    if (rst) begin
      wq.delete(); lat_q.delete();
      prev_en = 1'b0; prev_rs = 1'b0; prev_data = 8'd0; prev_idone = 1'b0;
      post = 1'b0; acc_trk = 1'b0; first_en = 1'b0;
      hi_cnt = 0; low_cnt = 0; pulses = 0; por_smp = 0; acc_smp = 0;
    end else begin
      if (acc_trk) begin
        acc_smp++;
        if (lcd_en && !prev_en && !first_en) begin
          first_en = 1'b1;
          chk("en_rise_after_accept", acc_smp, 2);
        end
        if (char_ready) begin
          acc_trk = 1'b0;
          if (lat_q.size() == 0) fail("ready_without_request", acc_smp);
          else chk("ready_latency", acc_smp - 1, lat_q.pop_front());
        end
      end

      if (lcd_en && !prev_en) begin
        if (pulses == 0) chk_rng("por_wait", por_smp, POR, POR + 4);
        if (pulses < 4) chk("init_done_during_init", init_done, 0);
        if (post) chk_rng("exec_gap", low_cnt, cur.exec + 1, cur.exec + 2);
        post = 1'b0; hi_cnt = 1; pulses++;
        if (wq.size() == 0) begin
          fail("unexpected_pulse", lcd_data);
          cur.rs = lcd_rs; cur.data = lcd_data; cur.exec = EXEC;
        end else begin
          cur = wq.pop_front();
          chk("rs", lcd_rs, cur.rs);
          chk("data", lcd_data, cur.data);
          chk("setup_rs", prev_rs, cur.rs);
          chk("setup_data", prev_data, cur.data);
          chk("rw", lcd_rw, 0);
        end
      end else if (lcd_en) begin
        hi_cnt++;
        chk("data_during_en", lcd_data, cur.data);
      end else if (prev_en) begin
        chk("en_width", hi_cnt, EN);
        post = 1'b1; low_cnt = 1;
        chk("hold_data", lcd_data, cur.data);
        chk("hold_rs", lcd_rs, cur.rs);
      end else if (post) begin
        low_cnt++;
        if (low_cnt <= cur.exec) chk("hold_data", lcd_data, cur.data);
      end

      if (post && char_ready) begin
        chk("exec_wait", low_cnt - 1, cur.exec);
        post = 1'b0;
      end
      if (pulses == 0 && !lcd_en) por_smp++;
      if (init_done && !prev_idone) chk("init_pulses", pulses, 4);
      if (prev_idone) chk("init_done_sticky", init_done, 1);
      if (char_valid && char_ready) begin
        acc_trk = 1'b1; acc_smp = 0; first_en = 1'b0;
      end

      prev_en = lcd_en; prev_rs = lcd_rs; prev_data = lcd_data; prev_idone = init_done;
    end
  end

  // Stimulus (drives at posedge+1)
  task automatic wait_accept(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!char_ready && n < 300);
    ok = char_ready;
    if (!ok) begin
      fail("ready_timeout", n);
    end else begin
      @(posedge clk);
      model_issue(char_data, char_is_cmd);
      #1;
    end
  endtask

  task automatic send(logic [7:0] d, bit is_cmd);
    bit ok;
    char_valid = 1'b1; char_data = d; char_is_cmd = is_cmd;
    wait_accept(ok);
    char_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!init_done) fail("init_timeout", n);
    @(posedge clk); #1;
  endtask

  task automatic gap();
    int g = $urandom_range(0, 2);
    repeat (g) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] cmd_tab [8] = '{8'h01, 8'h02, 8'h03, 8'h06, 8'h0C, 8'h0E, 8'h14, 8'h18};

  initial begin
    bit ok;
    logic [7:0] b;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", lcd_en, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_rw", lcd_rw, 0);
    rst = 1'b0;
    model_init();
    wait_init();

    send(8'h41, 1'b0);
    gap();
    send(8'h01, 1'b1);
    for (int i = 0; i < 32; i++) begin
      b = 8'(8'h20 + $urandom_range(0, 94));
      send(b, 1'b0);
    end

    // Valid held across a busy period: only bytes seen while ready are written.
    char_valid = 1'b1; char_is_cmd = 1'b0;
    char_data = 8'(8'h30 + $urandom_range(0, 9));
    wait_accept(ok);
    char_data = 8'h7E;
    repeat (3) begin
      @(posedge clk); #1;
    end
    char_data = 8'(8'h61 + $urandom_range(0, 20));
    wait_accept(ok);
    char_valid = 1'b0;

    for (int i = 0; i < 60; i++) begin
      gap();
      if ($urandom_range(0, 9) < 3) begin
        if ($urandom_range(0, 1) == 1) b = cmd_tab[$urandom_range(0, 7)];
        else b = 8'(8'h80 | $urandom_range(0, 127));
        send(b, 1'b1);
      end else begin
        b = 8'(8'h20 + $urandom_range(0, 94));
        send(b, 1'b0);
      end
    end

    // Reset while the enable strobe is high.
    char_valid = 1'b1; char_data = 8'h55; char_is_cmd = 1'b0;
    wait_accept(ok);
    char_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd_en && n < 20);
    if (!lcd_en) fail("en_timeout", n);
    #1 rst = 1'b1;
    #1;
    chk("midrst_en", lcd_en, 0);
    chk("midrst_rs", lcd_rs, 0);
    chk("midrst_data", lcd_data, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_ready", char_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_init();
    wait_init();
    send(8'h5A, 1'b0);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!char_ready && n < 300);
    repeat (3) @(posedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("lat_q_empty", lat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
